// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared opcode, state and register-file constants for the ALU issue controller
package alu_ctrl_pkg;

   localparam int OP_W     = 4;
   localparam int NUM_REGS = 16;
   localparam int REG_W    = 64;
   localparam int REG_RAX  = 0;
   localparam int REG_RDX  = 2;

   // Encodings 8..15 are left unassigned and decode as illegal.
   typedef enum logic [OP_W-1:0] {
      NOP    = 4'd0,
      ADD    = 4'd1,
      OR     = 4'd2,
      AND    = 4'd3,
      MOV    = 4'd4,
      MOVABS = 4'd5,
      IMUL   = 4'd6,
      RETQ   = 4'd7
   } op_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - decoded-instruction valid/ready bus into the ALU issue controller
interface alu_issue_ctrl_if;
   import alu_ctrl_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   in_op;
   logic [3:0]        in_dst;
   logic              in_b_is_imm;
   logic [3:0]        in_b_reg;
   logic [REG_W-1:0]  in_b_imm;

   modport master (
      output in_valid, in_op, in_dst, in_b_is_imm, in_b_reg, in_b_imm,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_op, in_dst, in_b_is_imm, in_b_reg, in_b_imm,
      output in_ready
   );

endinterface

// File: rtl/alu_imul_unit.sv
// rtl/alu_imul_unit.sv - fixed-latency unsigned 64x64->128 multiplier, present only with ALU_CTRL_IMUL_EN
`ifdef ALU_CTRL_IMUL_EN
module alu_imul_unit
   import alu_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [REG_W-1:0]   op_a,
   input  logic [REG_W-1:0]   op_b,
   output logic               done,
   output logic [2*REG_W-1:0] product
);

   logic [3:0]       cnt;
   logic             busy;
   logic [REG_W-1:0] a_q;
   logic [REG_W-1:0] b_q;

   // Capture operands on start, then count down; done is asserted while the count sits at zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         busy <= 1'b0;
         cnt  <= '0;
         a_q  <= '0;
         b_q  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= 4'(MUL_LAT - 1);
         a_q  <= op_a;
         b_q  <= op_b;
      end else if (busy) begin
         if (cnt == 4'd0) begin
            busy <= 1'b0;
         end else begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   assign done    = busy && (cnt == 4'd0);
   assign product = (2*REG_W)'(a_q) * (2*REG_W)'(b_q);

endmodule
`endif

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - execute-stage ALU sequencer and register file; IMUL gated by ALU_CTRL_IMUL_EN
module alu_issue_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   alu_issue_ctrl_if.slave              in_bus,
   output logic [0:NUM_REGS*REG_W-1]    reg_file,
   output logic                         retire_valid,
   output op_t                          retire_op,
   output logic                         illegal,
   output logic                         halted,
   output logic [CNT_W-1:0]             retire_count
);

   state_t             state;
   logic [REG_W-1:0]   regs [NUM_REGS];

   logic               accept;
   logic [REG_W-1:0]   val_a;
   logic [REG_W-1:0]   val_b;
   logic               wr_en;
   logic [REG_W-1:0]   wr_val;
   logic               do_retire;
   logic               do_illegal;
   logic               do_mul;
   logic               do_halt;
   logic               mul_done;
   logic [2*REG_W-1:0] mul_product;

   // Ready is decoded from the state register and held low throughout reset.
   assign in_bus.in_ready = reset && (state == IDLE);
   assign accept          = in_bus.in_valid && in_bus.in_ready;

   // Operand fetch and single-cycle ALU decode of the offered instruction.
   always_comb begin
      val_a      = regs[in_bus.in_dst];
      val_b      = in_bus.in_b_is_imm ? in_bus.in_b_imm : regs[in_bus.in_b_reg];
      wr_en      = 1'b0;
      wr_val     = '0;
      do_retire  = 1'b0;
      do_illegal = 1'b0;
      do_mul     = 1'b0;
      do_halt    = 1'b0;
      case (in_bus.in_op)
         NOP:        do_retire = 1'b1;
         ADD: begin
            wr_en = 1'b1; wr_val = val_a + val_b; do_retire = 1'b1;
         end
         OR: begin
            wr_en = 1'b1; wr_val = val_a | val_b; do_retire = 1'b1;
         end
         AND: begin
            wr_en = 1'b1; wr_val = val_a & val_b; do_retire = 1'b1;
         end
         MOV, MOVABS: begin
            wr_en = 1'b1; wr_val = val_b; do_retire = 1'b1;
         end
`ifdef ALU_CTRL_IMUL_EN
         IMUL:       do_mul = 1'b1;
`endif
         RETQ: begin
            do_retire = 1'b1; do_halt = 1'b1;
         end
         default:    do_illegal = 1'b1;
      endcase
   end

`ifdef ALU_CTRL_IMUL_EN
   alu_imul_unit #(
      .MUL_LAT (MUL_LAT)
   ) u_imul (
      .clk     (clk),
      .reset   (reset),
      .start   (accept && do_mul),
      .op_a    (val_a),
      .op_b    (val_b),
      .done    (mul_done),
      .product (mul_product)
   );
`else
   logic [3:0] unused_mul_lat;
   assign unused_mul_lat = 4'(MUL_LAT);
   assign mul_done       = 1'b0;
   assign mul_product    = '0;
`endif

   // Issue FSM: register writes land on the acceptance edge, status pulses follow one cycle later.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         retire_valid <= 1'b0;
         retire_op    <= NOP;
         illegal      <= 1'b0;
         halted       <= 1'b0;
         retire_count <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         retire_valid <= 1'b0;
         illegal      <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (wr_en) begin
                     regs[in_bus.in_dst] <= wr_val;
                  end
                  if (do_retire) begin
                     retire_valid <= 1'b1;
                     retire_op    <= op_t'(in_bus.in_op);
                     retire_count <= retire_count + CNT_W'(1);
                  end
                  if (do_illegal) begin
                     illegal <= 1'b1;
                  end
                  if (do_mul) begin
                     state <= MUL_WAIT;
                  end
                  if (do_halt) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end
               end
            end
            MUL_WAIT: begin
               if (mul_done) begin
                  regs[REG_RAX] <= mul_product[REG_W-1:0];
                  regs[REG_RDX] <= mul_product[2*REG_W-1:REG_W];
                  retire_valid  <= 1'b1;
                  retire_op     <= IMUL;
                  retire_count  <= retire_count + CNT_W'(1);
                  state         <= IDLE;
               end
            end
            HALT:    state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end

   // Flatten the register file with register 0 in the lowest-numbered bits.
   for (genvar n = 0; n < NUM_REGS; n++) begin : g_flat
      assign reg_file[n*REG_W +: REG_W] = regs[n];
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed table-driven bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
   import alu_ctrl_pkg::*;

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  dst;
      logic        is_imm;
      logic [3:0]  breg;
      logic [63:0] imm;
      int          chk_reg;
      logic [63:0] exp_val;
      logic        exp_ret;
      logic        exp_ill;
   } vec_t;

   logic                 clk;
   logic                 reset;
   logic [0:1023]        reg_file;
   logic                 retire_valid;
   op_t                  retire_op;
   logic                 illegal;
   logic                 halted;
   logic [31:0]          retire_count;

   int                   checks;
   int                   passed;
   int                   exp_cnt;
   vec_t                 vecs [11];

   alu_issue_ctrl_if bus ();

   alu_issue_ctrl #(
      .MUL_LAT (4),
      .CNT_W   (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_bus       (bus),
      .reg_file     (reg_file),
      .retire_valid (retire_valid),
      .retire_op    (retire_op),
      .illegal      (illegal),
      .halted       (halted),
      .retire_count (retire_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] rd(input int n);
      return reg_file[n*64 +: 64];
   endfunction

   function automatic vec_t mk(input logic [3:0] op, input logic [3:0] dst, input logic is_imm,
                               input logic [3:0] breg, input logic [63:0] imm, input int chk_reg,
                               input logic [63:0] exp_val, input logic exp_ret, input logic exp_ill);
      vec_t v;
      v.op = op; v.dst = dst; v.is_imm = is_imm; v.breg = breg; v.imm = imm;
      v.chk_reg = chk_reg; v.exp_val = exp_val; v.exp_ret = exp_ret; v.exp_ill = exp_ill;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [3:0] dst, input logic is_imm,
                        input logic [3:0] breg, input logic [63:0] imm);
      bus.in_valid    = 1'b1;
      bus.in_op       = op;
      bus.in_dst      = dst;
      bus.in_b_is_imm = is_imm;
      bus.in_b_reg    = breg;
      bus.in_b_imm    = imm;
   endtask

   initial begin
      logic [63:0] acc;
      checks = 0; passed = 0; exp_cnt = 0;

      vecs[0]  = mk(4'(MOVABS), 4'd1, 1'b1, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
      vecs[1]  = mk(4'(ADD),    4'd1, 1'b1, 4'd0, 64'd2,     1, 64'h1,   1'b1, 1'b0);
      vecs[2]  = mk(4'(MOV),    4'd3, 1'b1, 4'd0, 64'd5,     3, 64'h5,   1'b1, 1'b0);
      vecs[3]  = mk(4'(OR),     4'd3, 1'b1, 4'd0, 64'hA,     3, 64'hF,   1'b1, 1'b0);
      vecs[4]  = mk(4'(AND),    4'd3, 1'b0, 4'd3, 64'h0,     3, 64'hF,   1'b1, 1'b0);
      vecs[5]  = mk(4'(MOV),    4'd4, 1'b0, 4'd3, 64'h0,     4, 64'hF,   1'b1, 1'b0);
      vecs[6]  = mk(4'(ADD),    4'd4, 1'b0, 4'd1, 64'h0,     4, 64'h10,  1'b1, 1'b0);
      vecs[7]  = mk(4'hC,       4'd4, 1'b1, 4'd0, 64'hFF,    4, 64'h10,  1'b0, 1'b1);
      vecs[8]  = mk(4'(NOP),    4'd4, 1'b1, 4'd0, 64'h55,    4, 64'h10,  1'b1, 1'b0);
      vecs[9]  = mk(4'(AND),    4'd4, 1'b1, 4'd0, 64'h30,    4, 64'h10,  1'b1, 1'b0);
      vecs[10] = mk(4'(OR),     4'd5, 1'b1, 4'd0, 64'h123,   5, 64'h123, 1'b1, 1'b0);

      reset = 1'b0;
      bus.in_valid = 1'b0; bus.in_op = '0; bus.in_dst = '0;
      bus.in_b_is_imm = 1'b0; bus.in_b_reg = '0; bus.in_b_imm = '0;
      repeat (3) step();

      // Reset state
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_retire_valid", 64'(retire_valid), 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_retire_count", 64'(retire_count), 64'd0);
      chk("rst_retire_op", 64'(retire_op), 64'(NOP));
      acc = '0;
      for (int i = 0; i < 16; i++) acc = acc | rd(i);
      chk("rst_regs_zero", acc, 64'd0);
      reset = 1'b1;
      #1;
      chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Back-to-back single-cycle vectors with in_valid held high
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].op, vecs[i].dst, vecs[i].is_imm, vecs[i].breg, vecs[i].imm);
         chk($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
         step();
         chk($sformatf("v%0d_retire_valid", i), 64'(retire_valid), 64'(vecs[i].exp_ret));
         chk($sformatf("v%0d_illegal", i), 64'(illegal), 64'(vecs[i].exp_ill));
         chk($sformatf("v%0d_reg", i), rd(vecs[i].chk_reg), vecs[i].exp_val);
         if (vecs[i].exp_ret) chk($sformatf("v%0d_retire_op", i), 64'(retire_op), 64'(vecs[i].op));
         if (vecs[i].exp_ret) exp_cnt++;
      end
      bus.in_valid = 1'b0;
      chk("table_retire_count", 64'(retire_count), 64'(exp_cnt));

`ifdef ALU_CTRL_IMUL_EN
      // IMUL latency, writeback and stall
      drive(4'(MOVABS), 4'd0, 1'b1, 4'd0, 64'h8000_0000_0000_0000);
      step(); exp_cnt++;
      chk("imul_r0_setup", rd(0), 64'h8000_0000_0000_0000);
      drive(4'(IMUL), 4'd0, 1'b1, 4'd0, 64'd4);
      step();
      drive(4'(MOV), 4'd5, 1'b1, 4'd0, 64'd7);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("imul_stall%0d_in_ready", k), 64'(bus.in_ready), 64'd0);
         chk($sformatf("imul_stall%0d_retire", k), 64'(retire_valid), 64'd0);
         step();
      end
      exp_cnt++;
      chk("imul_rax", rd(0), 64'h0);
      chk("imul_rdx", rd(2), 64'h2);
      chk("imul_retire_valid", 64'(retire_valid), 64'd1);
      chk("imul_retire_op", 64'(retire_op), 64'(IMUL));
      chk("imul_no_early_accept", rd(5), 64'h123);
      chk("imul_ready_back", 64'(bus.in_ready), 64'd1);
      step(); exp_cnt++;
      chk("imul_next_accepted", rd(5), 64'h7);
      chk("imul_retire_count", 64'(retire_count), 64'(exp_cnt));

      // Reset in the middle of MUL_WAIT aborts the multiply
      drive(4'(IMUL), 4'd5, 1'b1, 4'd0, 64'd3);
      step();
      bus.in_valid = 1'b0;
      step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      exp_cnt = 0;
      #1;
      chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
      drive(4'(MOV), 4'd0, 1'b1, 4'd0, 64'd9);
      step(); exp_cnt++;
      bus.in_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("abort_no_retire%0d", k), 64'(retire_valid), 64'd0);
      end
      chk("abort_rax", rd(0), 64'd9);
      chk("abort_rdx", rd(2), 64'd0);
      chk("abort_retire_count", 64'(retire_count), 64'(exp_cnt));
`else
      // IMUL disabled: treated as an illegal opcode
      drive(4'(MOV), 4'd0, 1'b1, 4'd0, 64'd5);
      step(); exp_cnt++;
      drive(4'(IMUL), 4'd0, 1'b1, 4'd0, 64'd4);
      step();
      bus.in_valid = 1'b0;
      chk("noimul_illegal", 64'(illegal), 64'd1);
      chk("noimul_retire_valid", 64'(retire_valid), 64'd0);
      chk("noimul_rax", rd(0), 64'd5);
      chk("noimul_rdx", rd(2), 64'd0);
      chk("noimul_in_ready", 64'(bus.in_ready), 64'd1);
      chk("noimul_retire_count", 64'(retire_count), 64'(exp_cnt));
`endif

      // RETQ halts permanently and freezes state
      drive(4'(RETQ), 4'd6, 1'b1, 4'd0, 64'd0);
      step(); exp_cnt++;
      chk("retq_retire_valid", 64'(retire_valid), 64'd1);
      chk("retq_halted", 64'(halted), 64'd1);
      chk("retq_retire_op", 64'(retire_op), 64'(RETQ));
      chk("retq_retire_count", 64'(retire_count), 64'(exp_cnt));
      drive(4'(MOV), 4'd6, 1'b1, 4'd0, 64'd9);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("halt%0d_in_ready", k), 64'(bus.in_ready), 64'd0);
         step();
         chk($sformatf("halt%0d_retire", k), 64'(retire_valid), 64'd0);
      end
      bus.in_valid = 1'b0;
      chk("halt_r6", rd(6), 64'd0);
      chk("halt_sticky", 64'(halted), 64'd1);
      chk("halt_count_frozen", 64'(retire_count), 64'(exp_cnt));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
